// File: rtl/random_multi_pkg.sv
// random_pkg: shared types and constants for the multi-channel random source.
package random_pkg;
    typedef enum logic {MODE_COUNTER, MODE_LFSR} rand_mode_t;
    typedef enum logic {CH_IDLE, CH_PENDING} ch_state_t;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_RESET_SEED = 16'hACE1;
    function automatic logic [15:0] lfsr_step(input logic [15:0] q);
        return (q >> 1) ^ (q[0] ? LFSR_TAPS : 16'h0000);
    endfunction
endpackage

// File: rtl/random_multi_if.sv
// random_multi_if: request/response bundle between requesters and the random source.
interface random_multi_if #(
    parameter int SIZE_BITS = 8,
    parameter int NUM_CH = 4
);
    import random_pkg::*;
    rand_mode_t mode;
    logic seed_load;
    logic [15:0] seed;
    logic [NUM_CH-1:0] rise;
    logic [SIZE_BITS-1:0] dout [NUM_CH];
    logic [NUM_CH-1:0] valid;
    logic [NUM_CH-1:0] busy;
    modport master (output mode, seed_load, seed, rise, input dout, valid, busy);
    modport slave (input mode, seed_load, seed, rise, output dout, valid, busy);
endinterface

// File: rtl/random_multi_lfsr.sv
// random_lfsr: 16-bit right-shifting Galois LFSR with seed load; a zero seed becomes 1.
module random_lfsr
    import random_pkg::*;
(
    input  logic        clk,
    input  logic        resetN,
    input  logic        load,
    input  logic [15:0] seed,
    output logic [15:0] q
);
    always_ff @(posedge clk or negedge resetN)
        if (!resetN) q <= LFSR_RESET_SEED;
        else if (load) q <= (seed == 16'h0000) ? 16'h0001 : seed;
        else q <= lfsr_step(q);
endmodule

// File: rtl/random_multi.sv
// random_multi: shared counter/LFSR random source serving NUM_CH edge-triggered requesters,
// one grant per cycle to the lowest pending channel.
module random_multi
    import random_pkg::*;
#(
    parameter int SIZE_BITS = 8,
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 255,
    parameter int NUM_CH = 4
) (
    input logic clk,
    input logic resetN,
    random_multi_if.slave bus
);
    localparam logic [SIZE_BITS-1:0] LO = SIZE_BITS'(MIN_VAL);
    localparam logic [SIZE_BITS-1:0] HI = SIZE_BITS'(MAX_VAL);
    localparam logic [SIZE_BITS-1:0] SPAN = SIZE_BITS'(MAX_VAL - MIN_VAL);
    localparam logic [SIZE_BITS-1:0] MID = SIZE_BITS'(MIN_VAL + (MAX_VAL - MIN_VAL) / 2);
    logic [SIZE_BITS-1:0] counter, cand, r;
    logic [15:0] lfsr;
    logic lfsr_unused;
    logic accept;
    logic [NUM_CH-1:0] rise_d, pend, grant;
    ch_state_t state [NUM_CH];
    ch_state_t state_next [NUM_CH];
    random_lfsr u_lfsr (
        .clk(clk),
        .resetN(resetN),
        .load(bus.seed_load),
        .seed(bus.seed),
        .q(lfsr)
    );
    // only the low SIZE_BITS of the LFSR feed the candidate
    assign lfsr_unused = ^lfsr;
    always_ff @(posedge clk or negedge resetN)
        if (!resetN) counter <= LO;
        else counter <= (counter >= HI) ? LO : counter + SIZE_BITS'(1);
    assign r = lfsr[SIZE_BITS-1:0];
    assign accept = (bus.mode == MODE_COUNTER) || (r <= SPAN);
    assign cand = (bus.mode == MODE_COUNTER) ? counter : LO + r;
    always_comb
        for (int i = 0; i < NUM_CH; i++)
            pend[i] = (state[i] == CH_PENDING);
    // isolate the lowest set pending bit
    assign grant = accept ? (pend & (~pend + NUM_CH'(1))) : '0;
    assign bus.busy = pend;
    always_comb
        for (int i = 0; i < NUM_CH; i++)
            state_next[i] = (state[i] == CH_IDLE)
                ? ((bus.rise[i] && !rise_d[i]) ? CH_PENDING : CH_IDLE)
                : (grant[i] ? CH_IDLE : CH_PENDING);
    always_ff @(posedge clk or negedge resetN)
        if (!resetN) begin
            rise_d <= '0;
            bus.valid <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                state[i] <= CH_IDLE;
                bus.dout[i] <= MID;
            end
        end else begin
            rise_d <= bus.rise;
            bus.valid <= grant;
            for (int i = 0; i < NUM_CH; i++) begin
                state[i] <= state_next[i];
                if (grant[i]) bus.dout[i] <= cand;
            end
        end
endmodule

// File: tb/tb_random_multi.sv
// tb_random_multi: scoreboard bench; stimulus pushes expected grants, monitors pop on valid.
module tb_random_multi;
    import random_pkg::*;
    logic clk = 1'b0;
    logic resetN = 1'b0;
    always #5 clk = ~clk;

    random_multi_if #(.SIZE_BITS(8), .NUM_CH(4)) bus();
    random_multi_if #(.SIZE_BITS(3), .NUM_CH(1)) bus_b();
    random_multi #(.SIZE_BITS(8), .MIN_VAL(0), .MAX_VAL(99), .NUM_CH(4)) dut (
        .clk(clk), .resetN(resetN), .bus(bus));
    random_multi #(.SIZE_BITS(3), .MIN_VAL(3), .MAX_VAL(5), .NUM_CH(1)) dut_b (
        .clk(clk), .resetN(resetN), .bus(bus_b));

    typedef struct {int ch; int val; bit lfsr;} exp_t;
    exp_t q_a[$];
    int q_b[$];
    int checks = 0, failures = 0, cyc = 0;
    int seen[3];
    int seq1[8], seq2[8];
    logic [15:0] m_lfsr, m_lfsr_prev;
    bit l_chk = 0, l_arm = 0, p_busy = 0;
    int p_r = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // independent cycle count and LFSR reference
    always @(posedge clk or negedge resetN)
        if (!resetN) begin
            cyc <= 0;
            m_lfsr <= 16'hACE1;
            m_lfsr_prev <= 16'hACE1;
        end else begin
            cyc <= cyc + 1;
            m_lfsr_prev <= m_lfsr;
            m_lfsr <= bus.seed_load ? ((bus.seed == 16'h0) ? 16'h0001 : bus.seed)
                                    : ({1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000));
        end

    always @(negedge clk) if (resetN) begin
        exp_t e;
        for (int i = 0; i < 4; i++) if (bus.valid[i]) begin
            if (q_a.size() == 0) check($sformatf("unexpected_valid%0d", i), 1, 0);
            else begin
                e = q_a.pop_front();
                check("grant_ch", i, e.ch);
                check($sformatf("dout%0d", i), int'(bus.dout[i]), e.lfsr ? int'(m_lfsr_prev[7:0]) : e.val);
                if (e.lfsr) check("lfsr_range", int'(bus.dout[i] <= 8'd99), 1);
            end
        end
        if (l_arm) check("lfsr_stall", int'(bus.valid[0]), int'(p_busy && p_r <= 99));
        l_arm = l_chk;
        p_busy = bus.busy[0];
        p_r = int'(m_lfsr[7:0]);
    end

    always @(negedge clk) if (resetN && bus_b.valid[0]) begin
        if (q_b.size() == 0) check("unexpected_valid_b", 1, 0);
        else check("dout_b", int'(bus_b.dout[0]), q_b.pop_front());
        if (bus_b.dout[0] >= 3'd3 && bus_b.dout[0] <= 3'd5) seen[int'(bus_b.dout[0]) - 3]++;
    end

    task automatic run_lfsr(output int seq[8]);
        int t;
        for (int k = 0; k < 8; k++) begin
            bus.rise[0] = 1'b1;
            q_a.push_back('{ch: 0, val: 0, lfsr: 1'b1});
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!bus.valid[0] && t < 200);
            if (t >= 200) check("lfsr_timeout", 1, 0);
            seq[k] = int'(bus.dout[0]);
            bus.rise[0] = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int j;
        bus.mode = MODE_COUNTER; bus.seed_load = 0; bus.seed = 0; bus.rise = '0;
        bus_b.mode = MODE_COUNTER; bus_b.seed_load = 0; bus_b.seed = 0; bus_b.rise = '0;
        #12;
        for (int i = 0; i < 4; i++) check($sformatf("reset_dout%0d", i), int'(bus.dout[i]), 49);
        check("reset_valid", int'(bus.valid), 0);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_dout_b", int'(bus_b.dout[0]), 4);
        @(negedge clk);
        resetN = 1'b1;

        // single request sampled at edge 10 latches counter value 10 at edge 11
        wait_cyc(9);
        bus.rise[0] = 1'b1;
        q_a.push_back('{ch: 0, val: 10, lfsr: 1'b0});
        @(negedge clk);
        check("latch_busy", int'(bus.busy[0]), 1);
        check("latch_no_early_valid", int'(bus.valid[0]), 0);
        @(negedge clk);
        check("latch_valid", int'(bus.valid[0]), 1);
        check("latch_busy_clear", int'(bus.busy[0]), 0);
        bus.rise[0] = 1'b0;

        // four-way contention straddling the 99 -> 0 wrap, plus a dropped edge on ch3
        wait_cyc(97);
        bus.rise = 4'hF;
        q_a.push_back('{ch: 0, val: 98, lfsr: 1'b0});
        q_a.push_back('{ch: 1, val: 99, lfsr: 1'b0});
        q_a.push_back('{ch: 2, val: 0, lfsr: 1'b0});
        q_a.push_back('{ch: 3, val: 1, lfsr: 1'b0});
        @(negedge clk);
        check("cont_busy_all", int'(bus.busy), 15);
        bus.rise = 4'h0;
        @(negedge clk);
        check("cont_busy_after_ch0", int'(bus.busy), 14);
        bus.rise[3] = 1'b1;
        wait_cyc(103);
        check("cont_drop_busy", int'(bus.busy), 0);
        bus.rise = 4'h0;

        // LFSR rejection sampling; seed 0 must reproduce seed 1
        wait_cyc(105);
        bus.mode = MODE_LFSR;
        @(negedge clk);
        bus.seed_load = 1'b1; bus.seed = 16'h0001;
        @(negedge clk);
        bus.seed_load = 1'b0;
        l_chk = 1;
        run_lfsr(seq1);
        bus.seed_load = 1'b1; bus.seed = 16'h0000;
        @(negedge clk);
        bus.seed_load = 1'b0;
        run_lfsr(seq2);
        for (int k = 0; k < 8; k++) check($sformatf("seed0_eq_seed1_%0d", k), seq2[k], seq1[k]);
        l_chk = 0;
        @(negedge clk);
        @(negedge clk);
        bus.mode = MODE_COUNTER;

        // narrow range 3..5 on the second instance
        for (int n = 0; n < 12; n++) begin
            j = cyc;
            bus_b.rise[0] = 1'b1;
            q_b.push_back(3 + (j + 1) % 3);
            @(negedge clk);
            bus_b.rise[0] = 1'b0;
            repeat (3) @(negedge clk);
        end
        for (int v = 0; v < 3; v++) check($sformatf("wrap_seen_%0d", v + 3), int'(seen[v] > 0), 1);

        // asynchronous reset while ch1 is pending
        bus.rise[1] = 1'b1;
        @(negedge clk);
        check("rst_mid_busy_before", int'(bus.busy[1]), 1);
        resetN = 1'b0;
        #1;
        check("rst_mid_busy", int'(bus.busy), 0);
        check("rst_mid_valid", int'(bus.valid), 0);
        check("rst_mid_dout0", int'(bus.dout[0]), 49);
        bus.rise = '0;
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        repeat (6) @(negedge clk);
        check("q_a_empty", q_a.size(), 0);
        check("q_b_empty", q_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
